knn_vote: RTL and testbench

KNN_VOTE -- requirements
Module: knn_vote

---
 rtl/knn_pkg.sv | 25 ++
 rtl/knn_vote_if.sv | 39 +++
 rtl/knn_vote_cnt.sv | 38 +++
 rtl/knn_vote.sv | 116 +++++++++++
 tb/tb_knn_vote.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: shared constants for the k-nearest-neighbour vote block.
//   K_MAX         - largest neighbour count that is ever voted
//   ST_*          - controller state encoding
//   idx_w / cls_w - derive point-index and class-label widths
package knn_pkg;

  localparam logic [3:0] K_MAX = 4'd10;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_READ = 3'd1;
  localparam logic [2:0] ST_VOTE = 3'd2;
  localparam logic [2:0] ST_SCAN = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Point index width follows the sorter distance width.
  function automatic int idx_w(input int w);
    return w / 4;
  endfunction

  // Class label width, never narrower than one bit.
  function automatic int cls_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/knn_vote_if.sv
// knn_vote_if: request, sorter and label-memory signals of knn_vote.
//   start/k/n_pts       - classify request
//   sel/idx_in          - sorter slot select and returned point index
//   lbl_en/lbl_addr/lbl_data - label memory read port (1-cycle latency)
//   busy/done/class_out/votes - status and result
// Modport slave is the voter; master is its environment.
interface knn_vote_if #(
  parameter int W      = 32,
  parameter int NCLASS = 4
);
  import knn_pkg::*;

  localparam int IDX_W = idx_w(W);
  localparam int CLS_W = cls_w(NCLASS);

  logic             start;
  logic [3:0]       k;
  logic [IDX_W-1:0] n_pts;
  logic [3:0]       sel;
  logic [IDX_W-1:0] idx_in;
  logic             lbl_en;
  logic [IDX_W-1:0] lbl_addr;
  logic [CLS_W-1:0] lbl_data;
  logic             busy;
  logic             done;
  logic [CLS_W-1:0] class_out;
  logic [3:0]       votes;

  modport slave (
    input  start, k, n_pts, idx_in, lbl_data,
    output sel, lbl_en, lbl_addr, busy, done, class_out, votes
  );

  modport master (
    output start, k, n_pts, idx_in, lbl_data,
    input  sel, lbl_en, lbl_addr, busy, done, class_out, votes
  );

endinterface

// File: rtl/knn_vote_cnt.sv
// knn_vote_cnt: per-class 4-bit vote counter bank.
//   clk, rst - clock, synchronous active-high reset
//   clr      - zero all counters
//   inc      - add one to counter inc_cls (labels >= NCLASS are dropped)
//   rd_cls   - class to read, rd_cnt its count (0 when out of range)
module knn_vote_cnt #(
  parameter int NCLASS = 4,
  parameter int CLS_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [CLS_W-1:0] inc_cls,
  input  logic [3:0]       rd_cls,
  output logic [3:0]       rd_cnt
);

  logic [3:0] cnt [NCLASS];

  // Matching by loop rather than indexing makes out-of-range labels
  // fall through without a vote.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < NCLASS; i++) cnt[i] <= '0;
    end else if (inc) begin
      for (int unsigned i = 0; i < NCLASS; i++)
        if (inc_cls == CLS_W'(i)) cnt[i] <= cnt[i] + 4'd1;
    end
  end

  always_comb begin
    rd_cnt = '0;
    for (int unsigned i = 0; i < NCLASS; i++)
      if (rd_cls == 4'(i)) rd_cnt = cnt[i];
  end

endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over the k nearest neighbours held by a sorter.
//   clk, rst - clock, synchronous active-high reset
//   bus      - knn_vote_if slave: start/k/n_pts request, sorter slot
//              select (sel/idx_in), label read (lbl_en/lbl_addr/lbl_data),
//              busy/done status, class_out/votes result.
// Reads k_eff labels (READ/VOTE pairs), scans the class counters in
// ascending order keeping the first strict maximum, then pulses done.
module knn_vote #(
  parameter int W      = 32,
  parameter int NCLASS = 4
) (
  input logic       clk,
  input logic       rst,
  knn_vote_if.slave bus
);
  import knn_pkg::*;

  localparam int IDX_W = idx_w(W);
  localparam int CLS_W = cls_w(NCLASS);

  logic [2:0]       state;
  logic [3:0]       j;
  logic [3:0]       k_eff;
  logic [3:0]       k_lim;
  logic [3:0]       k_new;
  logic [3:0]       best_cnt;
  logic [CLS_W-1:0] best_cls;
  logic [CLS_W-1:0] class_q;
  logic [3:0]       votes_q;
  logic [3:0]       cnt_rd;
  logic             take;
  logic             accept;

  // k_eff = min(k, K_MAX, n_pts)
  always_comb begin
    k_lim = (bus.k > K_MAX) ? K_MAX : bus.k;
    k_new = k_lim;
    if (int'(bus.n_pts) < int'(k_lim)) k_new = 4'(bus.n_pts);
  end

  assign accept = (state == ST_IDLE) && bus.start;
  assign take   = (cnt_rd > best_cnt);

  knn_vote_cnt #(
    .NCLASS (NCLASS),
    .CLS_W  (CLS_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .inc     (state == ST_VOTE),
    .inc_cls (bus.lbl_data),
    .rd_cls  (j),
    .rd_cnt  (cnt_rd)
  );

  // j counts label reads, then is reused as the class index during SCAN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      j        <= '0;
      k_eff    <= '0;
      best_cnt <= '0;
      best_cls <= '0;
      class_q  <= '0;
      votes_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            k_eff    <= k_new;
            j        <= '0;
            best_cnt <= '0;
            best_cls <= '0;
            state    <= (k_new == 4'd0) ? ST_SCAN : ST_READ;
          end
        end
        ST_READ: state <= ST_VOTE;
        ST_VOTE: begin
          if ((j + 4'd1) == k_eff) begin
            j     <= '0;
            state <= ST_SCAN;
          end else begin
            j     <= j + 4'd1;
            state <= ST_READ;
          end
        end
        ST_SCAN: begin
          if (take) begin
            best_cnt <= cnt_rd;
            best_cls <= j[CLS_W-1:0];
          end
          // Result is registered on the last scan edge so it is valid with done.
          if (j == 4'(NCLASS - 1)) begin
            class_q <= take ? j[CLS_W-1:0] : best_cls;
            votes_q <= take ? cnt_rd : best_cnt;
            state   <= ST_DONE;
          end else begin
            j <= j + 4'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sel       = (state == ST_READ) ? j : 4'd0;
  assign bus.lbl_en    = (state == ST_READ);
  assign bus.lbl_addr  = (state == ST_READ) ? bus.idx_in : {IDX_W{1'b0}};
  assign bus.busy      = (state == ST_READ) || (state == ST_VOTE) || (state == ST_SCAN);
  assign bus.done      = (state == ST_DONE);
  assign bus.class_out = class_q;
  assign bus.votes     = votes_q;

endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed self-checking bench for knn_vote (NCLASS=4, W=32).
// Models the sorter as idx = 7*slot + 3 and a 1-cycle label memory.
module tb_knn_vote;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  logic [1:0] lbl_mem [256];

  always #5 clk = ~clk;

  knn_vote_if #(.W(32), .NCLASS(4)) bus ();

  knn_vote #(.W(32), .NCLASS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always_comb bus.idx_in = {4'd0, bus.sel} * 8'd7 + 8'd3;

  always_ff @(posedge clk)
    if (bus.lbl_en) bus.lbl_data <= lbl_mem[bus.lbl_addr];

  function automatic int idx_of(input int s);
    return s * 7 + 3;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_sel"},   int'(bus.sel), 0);
    check({tag, "_lblen"}, int'(bus.lbl_en), 0);
    check({tag, "_addr"},  int'(bus.lbl_addr), 0);
    check({tag, "_busy"},  int'(bus.busy), 0);
    check({tag, "_done"},  int'(bus.done), 0);
    check({tag, "_cls"},   int'(bus.class_out), 0);
    check({tag, "_votes"}, int'(bus.votes), 0);
  endtask

  // Called at a negedge; labs holds slot labels, slot 0 in the low nibble.
  task automatic run(input string tag, input logic [3:0] kv, input int np,
                     input logic [39:0] labs, input int ecls, input int evot,
                     input int elat, input int erd, input bit poke);
    int lat, reads;
    bit sel_ok, addr_ok, busy_ok, extra_done;
    for (int s = 0; s < 10; s++) lbl_mem[idx_of(s)] = labs[4*s +: 2];
    bus.k = kv;
    bus.n_pts = 8'(np);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = -1; reads = 0; sel_ok = 1; addr_ok = 1; busy_ok = 1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(negedge clk);
      bus.start = (poke && (n == 3 || n == 8)) ? 1'b1 : 1'b0;
      if (bus.lbl_en) begin
        if (int'(bus.sel) != reads) sel_ok = 0;
        if (int'(bus.lbl_addr) != idx_of(reads)) addr_ok = 0;
        reads++;
      end
      if (bus.done) lat = n;
      else if (!bus.busy) busy_ok = 0;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, lat, elat);
    check({tag, "_class"},   int'(bus.class_out), ecls);
    check({tag, "_votes"},   int'(bus.votes), evot);
    check({tag, "_reads"},   reads, erd);
    check({tag, "_sel_seq"}, int'(sel_ok), 1);
    check({tag, "_addr"},    int'(addr_ok), 1);
    check({tag, "_busy"},    int'(busy_ok), 1);
    @(negedge clk);
    check({tag, "_done_1cyc"}, int'(bus.done), 0);
    check({tag, "_hold_cls"},  int'(bus.class_out), ecls);
    check({tag, "_hold_vot"},  int'(bus.votes), evot);
    if (poke) begin
      extra_done = 0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (bus.done || bus.busy) extra_done = 1;
      end
      check({tag, "_no_queue"}, int'(extra_done), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit saw_done;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.k = '0;
    bus.n_pts = '0;
    for (int i = 0; i < 256; i++) lbl_mem[i] = 2'd0;
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run("maj",   4'd5,  20, 40'h00000_23212, 2, 3,  15, 5,  1'b0);
    run("tie",   4'd4,  20, 40'h00000_03113, 1, 2,  13, 4,  1'b0);
    run("npts",  4'd10, 3,  40'h33333_33100, 0, 2,  11, 3,  1'b0);
    run("k1",    4'd1,  20, 40'h00000_00003, 3, 1,  7,  1,  1'b0);
    run("clamp", 4'd12, 50, 40'h33333_33333, 3, 10, 25, 10, 1'b0);

    // Abort in the second VOTE cycle; previous result is nonzero.
    for (int s = 0; s < 10; s++) lbl_mem[idx_of(s)] = 2'd1;
    bus.k = 4'd5;
    bus.n_pts = 8'd20;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    saw_done = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    check("abort_in_vote", int'(bus.busy), 1);
    rst = 1'b1;
    @(negedge clk);
    if (bus.done) saw_done = 1;
    check_idle_zero("abort");
    check("abort_no_done", int'(saw_done), 0);
    rst = 1'b0;
    run("after_rst", 4'd5, 20, 40'h00000_23212, 2, 3, 15, 5, 1'b1);

    run("k0",    4'd0,  20, 40'h33333_33333, 0, 0,  5,  0,  1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
